bin2bcd_seq: RTL and testbench

Iterative double-dabble binary-to-BCD converter that sits directly upstream of the four-digit seven-segment display multiplexer. It accepts a binary value on a start/busy/done handshake and produces four BCD digits plus a leading-zero blank mask. The display stage consumes these results. Results are held stable between conversions, so the display can sample them on any cycle.

---
 rtl/bin2bcd_seq_pkg.sv | 15 +
 rtl/bin2bcd_seq_bcd_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 tb/tb_bin2bcd_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types for the sequential binary-to-BCD converter.
// Holds FSM state encoding, digit count and the BCD nibble type.
package bin2bcd_seq_pkg;

  localparam int DIGITS = 4;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 when the nibble is >= 5.
// Ports: d = scratch nibble in, q = corrected nibble (no carry out).
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  bcd_t d,
  output bcd_t q
);

  assign q = (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter feeding the 4-digit display mux.
// Ports: clk, rst (async high), start/bin in; busy, done, digits, blank, ovf out.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = 14
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  // One spare nibble above the display digits catches overflow.
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(BIN_W);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [BIN_W-1:0] bin_sr;
  logic [SW-1:0]    scr;
  logic [SW-1:0]    scr_c;
  logic             accept;
  logic             last;

  logic                ovf_n;
  logic [4*DIGITS-1:0] dig_n;
  logic [DIGITS-1:0]   blank_n;
  logic                zrun;

  // DONE also accepts start, giving back-to-back conversions.
  assign accept = start & ((state == S_IDLE) | (state == S_DONE));
  assign last   = (cnt == CW'(BIN_W - 1));

  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scr[4*g +: 4]),
      .q (scr_c[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_SHIFT;
      S_SHIFT: if (last)  state_n = S_DONE;
      S_DONE:  state_n = start ? S_SHIFT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bin_sr <= '0;
      scr    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      bin_sr <= bin;
      scr    <= '0;
    end else if (state == S_SHIFT) begin
      // Correct first, then shift {scratch,binary} left by one.
      scr    <= {scr_c[SW-2:0], bin_sr[BIN_W-1]};
      bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
      cnt    <= cnt + 1'b1;
    end
  end

  always_comb begin
    ovf_n = |scr[SW-1 -: 4];
    dig_n = ovf_n ? {DIGITS{4'h9}} : scr[4*DIGITS-1:0];
    blank_n = '0;
    zrun = 1'b1;
    // Walk down from the top digit; ones is never blanked.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun = zrun & (dig_n[4*i +: 4] == 4'd0);
      blank_n[i] = zrun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      digits <= '0;
      blank  <= {{(DIGITS-1){1'b1}}, 1'b0};
      ovf    <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        digits <= dig_n;
        blank  <= blank_n;
        ovf    <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq.
// Reference model uses decimal arithmetic on the integer value.
module tb_bin2bcd_seq;

  localparam int BW = 14;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        ovf;

  int n_cmp;
  int n_err;
  logic [15:0] prev_dig;

  bin2bcd_seq #(.BIN_W(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .digits (digits),
    .blank  (blank),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int v,
                       output logic [15:0] d,
                       output logic [3:0] b,
                       output logic o);
    if (v > 9999) begin
      d = 16'h9999;
      b = 4'b0000;
      o = 1'b1;
    end else begin
      d[15:12] = 4'((v / 1000) % 10);
      d[11:8]  = 4'((v / 100) % 10);
      d[7:4]   = 4'((v / 10) % 10);
      d[3:0]   = 4'(v % 10);
      b = {v < 1000, v < 100, v < 10, 1'b0};
      o = 1'b0;
    end
  endtask

  // Called #1 after an edge; start is accepted on the next edge.
  task automatic launch(input int v);
    start = 1'b1;
    bin = 14'(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin = 14'($urandom);
  endtask

  // Called #1 after the accept edge. poke: cycle to pulse a stray
  // start (-1 none). nxt: value to chain in during DONE (-1 none).
  task automatic wait_done(input int v, input int poke, input int nxt);
    int k;
    int nb;
    bit seen;
    logic [15:0] ed;
    logic [3:0] eb;
    logic eo;
    k = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (busy) nb++;
      if (k == poke) begin
        start = 1'b1;
        bin = 14'd99;
      end else if (nxt >= 0 && k == BW) begin
        start = 1'b1;
        bin = 14'(nxt);
      end else begin
        start = 1'b0;
      end
      if (k == 5) chk("hold", 32'(digits), 32'(prev_dig));
      @(posedge clk); #1;
      k++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("latency", k, BW + 1);
    chk("busy_cycles", nb, BW);
    model(v, ed, eb, eo);
    chk($sformatf("digits(%0d)", v), 32'(digits), 32'(ed));
    chk($sformatf("blank(%0d)", v), 32'(blank), 32'(eb));
    chk($sformatf("ovf(%0d)", v), 32'(ovf), 32'(eo));
    prev_dig = ed;
    if (nxt < 0) begin
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dir [7];
    int nd;
    n_cmp = 0;
    n_err = 0;
    prev_dig = 16'h0;
    start = 1'b0;
    bin = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_blank", 32'(blank), 32'b1110);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    dir = '{0, 1234, 7, 56, 9999, 10000, 16383};
    foreach (dir[i]) begin
      launch(dir[i]);
      wait_done(dir[i], -1, -1);
    end

    for (int i = 0; i < 20; i++) begin
      int v;
      v = (i % 2 == 0) ? int'($urandom_range(0, 16383))
                       : int'($urandom_range(0, 9999));
      launch(v);
      wait_done(v, -1, -1);
    end

    // Stray start during SHIFT must be ignored.
    launch(42);
    wait_done(42, 4, -1);
    repeat (20) begin
      @(posedge clk); #1;
      if (done) chk("stray_done", 32'(done), 32'd0);
    end
    chk("after_stray", 32'(digits), 32'h0042);

    // Back-to-back: start held in DONE.
    launch(4321);
    wait_done(4321, -1, 321);
    wait_done(321, -1, -1);

    // Asynchronous reset mid-conversion.
    launch(8765);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_digits", 32'(digits), 32'd0);
    chk("arst_blank", 32'(blank), 32'b1110);
    chk("arst_done", 32'(done), 32'd0);
    #2 rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_no_done", nd, 0);
    prev_dig = 16'h0;
    nd = int'($urandom_range(0, 16383));
    launch(nd);
    wait_done(nd, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
